// File: rtl/tea_encryptor_iter_pkg.sv
// Shared TEA definitions: key-schedule constant, decrypt start sum and the
// encryptor FSM state type.
package tea_encryptor_iter_pkg;

    localparam logic [31:0] TEA_DELTA     = 32'h9E3779B9;
    // DELTA * 32 mod 2^32: where a 32-cycle decryption begins its sum.
    localparam logic [31:0] TEA_DEC_SUM   = 32'hC6EF3720;
    localparam int          TEA_ROUNDS    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tea_state_e;

endpackage

// File: rtl/tea_encryptor_iter_functionf.sv
// TEA round function F(x, s, a, b) = ((x<<4)+a) ^ (x+s) ^ ((x>>5)+b),
// all sums modulo 2^32 and the right shift logical.
module functionF (
    input  logic [31:0] inKeyL,
    input  logic [31:0] inKeyR,
    input  logic [31:0] sum,
    input  logic [31:0] chunk32,
    output logic [31:0] out32
);

    logic [31:0] term_l;
    logic [31:0] term_s;
    logic [31:0] term_r;

    assign term_l = (chunk32 << 4) + inKeyL;
    assign term_s = chunk32 + sum;
    assign term_r = (chunk32 >> 5) + inKeyR;
    assign out32  = term_l ^ term_s ^ term_r;

endmodule

// File: rtl/tea_encryptor_iter.sv
// Iterative TEA encryptor: one full TEA cycle (both halves) per clock,
// ROUNDS cycles per block, single-cycle done pulse on completion.
//
// state | meaning
// IDLE  | waiting for start; ciphertext holds the last result
// RUN   | one TEA cycle per clock; start is ignored here
// DONE  | done pulse; start here chains straight into the next block
module tea_encryptor_iter
    import tea_encryptor_iter_pkg::*;
#(
    parameter int          ROUNDS = TEA_ROUNDS,
    parameter logic [31:0] DELTA  = TEA_DELTA
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [127:0]  key,
    input  logic [63:0]   plaintext,
    output logic          busy,
    output logic          done,
    output logic [63:0]   ciphertext
);

    localparam int              CW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0]   LAST = CW'(ROUNDS - 1);

    tea_state_e     state_q, state_d;
    logic [127:0]   key_q,   key_d;
    logic [31:0]    v0_q,    v0_d;
    logic [31:0]    v1_q,    v1_d;
    logic [31:0]    sum_q,   sum_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [63:0]    ct_q,    ct_d;

    logic [31:0]    f0, f1;
    logic [31:0]    v0_n, v1_n;

    // Second half consumes the freshly updated V0 within the same clock.
    functionF u_f0 (
        .inKeyL  (key_q[31:0]),
        .inKeyR  (key_q[63:32]),
        .sum     (sum_q),
        .chunk32 (v1_q),
        .out32   (f0)
    );

    assign v0_n = v0_q + f0;

    functionF u_f1 (
        .inKeyL  (key_q[95:64]),
        .inKeyR  (key_q[127:96]),
        .sum     (sum_q),
        .chunk32 (v0_n),
        .out32   (f1)
    );

    assign v1_n = v1_q + f1;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ct_d    = ct_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
                    v0_d    = plaintext[31:0];
                    v1_d    = plaintext[63:32];
                    sum_d   = DELTA;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                v0_d  = v0_n;
                v1_d  = v1_n;
                sum_d = sum_q + DELTA;
                if (cnt_q == LAST) begin
                    ct_d    = {v1_n, v0_n};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                if (start) begin
                    key_d   = key;
                    v0_d    = plaintext[31:0];
                    v1_d    = plaintext[63:32];
                    sum_d   = DELTA;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            ct_q    <= ct_d;
        end
    end

    assign ciphertext = ct_q;

endmodule

// File: tb/tb_tea_encryptor_iter.sv
// Directed bench for tea_encryptor_iter: scoreboard of expected ciphertexts,
// reference encrypt/decrypt model, latency, abort and back-to-back checks.
module tb_tea_encryptor_iter;

    localparam logic [31:0] DELTA   = 32'h9E3779B9;
    localparam logic [31:0] DEC_SUM = 32'hC6EF3720;
    localparam int          LAT     = 33;  // sampling edge counted as edge 1

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [127:0]  key = '0;
    logic [63:0]   plaintext = '0;
    logic          busy;
    logic          done;
    logic [63:0]   ciphertext;

    int tests  = 0;
    int failed = 0;
    logic [63:0] exp_q[$];

    tea_encryptor_iter dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key        (key),
        .plaintext  (plaintext),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] x, input logic [31:0] s,
                                      input logic [31:0] a, input logic [31:0] b);
        return ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
    endfunction

    function automatic logic [63:0] tea_enc(input logic [127:0] k, input logic [63:0] p);
        logic [31:0] v0, v1, s;
        v0 = p[31:0]; v1 = p[63:32]; s = '0;
        for (int r = 0; r < 32; r++) begin
            s  = s + DELTA;
            v0 = v0 + f(v1, s, k[31:0], k[63:32]);
            v1 = v1 + f(v0, s, k[95:64], k[127:96]);
        end
        return {v1, v0};
    endfunction

    function automatic logic [63:0] tea_dec(input logic [127:0] k, input logic [63:0] c);
        logic [31:0] v0, v1, s;
        v0 = c[31:0]; v1 = c[63:32]; s = DEC_SUM;
        for (int r = 0; r < 32; r++) begin
            v1 = v1 - f(v0, s, k[95:64], k[127:96]);
            v0 = v0 - f(v1, s, k[31:0], k[63:32]);
            s  = s - DELTA;
        end
        return {v1, v0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [127:0] k, input logic [63:0] p);
        key       = k;
        plaintext = p;
        start     = 1'b1;
        exp_q.push_back(tea_enc(k, p));
    endtask

    // Called at a negedge with start already driven; returns at the negedge
    // where done is seen. poke_edge rewrites key/plaintext (and optionally
    // pulses start) right after that edge.
    task automatic wait_done(input string tag, input bit hold, input int poke_edge,
                             input bit poke_start);
        int   edges;
        bit   seen;
        bit   busy_bad;
        logic [63:0] exp;
        edges = 0; seen = 0; busy_bad = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            edges = i;
            if (i == 1 && !hold) start = 1'b0;
            if (i == poke_edge) begin
                key       = {$urandom, $urandom, $urandom, $urandom};
                plaintext = {$urandom, $urandom};
                start     = poke_start;
            end
            if (i == poke_edge + 1 && !hold) start = 1'b0;
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 64'(edges), 64'(LAT));
            return;
        end
        chk({tag, "_latency"}, 64'(edges), 64'(LAT));
        chk({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            chk({tag, "_ct"}, ciphertext, exp);
        end
    endtask

    initial begin
        logic [127:0] k;
        logic [63:0]  p, c0;
        bit           done_seen;

        // Reset is asynchronous: check before any clock edge.
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ct", ciphertext, 64'd0);
        chk("rst_v", {dut.v1_q, dut.v0_q}, 64'd0);
        chk("rst_sum_cnt", {dut.sum_q, 32'(dut.cnt_q)}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer zero vector.
        key = '0; plaintext = '0; start = 1'b1;
        exp_q.push_back(64'h94BAA940_41EA3A0A);
        wait_done("zero", 0, 0, 0);
        @(negedge clk);
        chk("zero_done_pulse", 64'(done), 64'd0);
        chk("zero_ct_hold", ciphertext, 64'h94BAA940_41EA3A0A);

        // start pulsed mid-RUN with a different plaintext is ignored.
        issue(128'h0123456789ABCDEF_FEDCBA9876543210, 64'hDEADBEEF_CAFEF00D);
        wait_done("startrun", 0, 10, 1);
        @(negedge clk);
        chk("startrun_idle_done", 64'(done), 64'd0);
        chk("startrun_idle_busy", 64'(busy), 64'd0);

        // Inputs change the cycle after acceptance; result uses latched ones.
        @(negedge clk);
        issue(128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 64'h01234567_89ABCDEF);
        wait_done("inflight", 0, 1, 0);

        // Reset mid-RUN aborts with no done pulse.
        @(negedge clk);
        key = {$urandom, $urandom, $urandom, $urandom};
        plaintext = {$urandom, $urandom};
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_ct", ciphertext, 64'd0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) done_seen = 1;
        end
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) done_seen = 1;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        issue(128'h00112233_44556677_8899AABB_CCDDEEFF, 64'h11111111_22222222);
        wait_done("after_abort", 0, 0, 0);

        // Back-to-back: start held high, three blocks at 33/66/99.
        @(negedge clk);
        issue(128'h1, 64'h1);
        wait_done("b2b_0", 1, 0, 0);
        issue(128'h2, 64'h2);
        wait_done("b2b_1", 1, 0, 0);
        issue(128'h3, 64'h3);
        wait_done("b2b_2", 1, 0, 0);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_end_busy", 64'(busy), 64'd0);

        // Round trip through the reference decryptor.
        for (int n = 0; n < 100; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom};
            issue(k, p);
            wait_done("rt", 0, 0, 0);
            c0 = ciphertext;
            chk("rt_decrypt", tea_dec(k, c0), p);
        end

        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
